tug_referee: RTL

TUG_REFEREE -- requirements
Module: tug_referee

---
 rtl/tug_pkg.sv | 28 ++
 rtl/key_press.sv | 30 +++
 rtl/tug_referee.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tug_pkg;

    // FSM encoding is visible on the state output, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PLAY       = 2'd1,
        ST_WON        = 2'd2,
        ST_MATCH_OVER = 2'd3
    } state_t;

    // Rope position: 0 is the human (right) edge, 8 the cyber (left) edge.
    localparam logic [3:0] POS_MIN    = 4'd0;
    localparam logic [3:0] POS_CENTRE = 4'd4;
    localparam logic [3:0] POS_MAX    = 4'd8;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_RIGHT = 2'b01;
    localparam logic [1:0] WIN_LEFT  = 2'b10;

    // One LED per rope position.
    function automatic logic [8:0] pos_onehot(input logic [3:0] p);
        pos_onehot = 9'd1 << p;
    endfunction

endpackage

// File: rtl/key_press.sv
// Synchronises a raw asynchronous button and emits a 1-cycle pulse per rising edge.
// Latency: press is high in the cycle after the 2nd clk edge following the key rise.
// Backpressure: none; a held key produces exactly one pulse.
// Ports: clk, reset (async active-low), key (raw button), press (1-cycle pulse).
module key_press (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/tug_referee.sv
// Referee for a human-vs-cyber tug of war: rope position, round/match scoring, LED display.
// Latency: a human key rise moves the rope on the 3rd clk edge; a cyber hit acts on its tick edge.
// Backpressure: none; presses outside PLAY (except IDLE start) are dropped.
// Ports: clk, reset (async active-low), human_key, cyber_hit in; leds, pos, scores, winner, state out.
module tug_referee
    import tug_pkg::*;
#(
    parameter int TICK_DIV   = 5_000_000,
    parameter int HOLD_TICKS = 50_000_000,
    parameter int WIN_SCORE  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       human_key,
    input  logic       cyber_hit,
    output logic [8:0] leds,
    output logic [3:0] pos,
    output logic [2:0] left_score,
    output logic [2:0] right_score,
    output logic [1:0] winner,
    output logic [1:0] state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    state_t        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic [2:0]    left_q, left_d;
    logic [2:0]    right_q, right_d;
    logic [1:0]    winner_q, winner_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [HW-1:0] hold_q, hold_d;

    logic       human_press;
    logic       tick;
    logic       cyber_press;
    logic [3:0] left_inc;
    logic [3:0] right_inc;

    key_press u_key_press (
        .clk   (clk),
        .reset (reset),
        .key   (human_key),
        .press (human_press)
    );

    assign tick        = (tick_q == TW'(TICK_DIV - 1));
    assign cyber_press = tick & cyber_hit;
    assign left_inc    = {1'b0, left_q} + 4'd1;
    assign right_inc   = {1'b0, right_q} + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pos_q    <= POS_CENTRE;
            left_q   <= 3'd0;
            right_q  <= 3'd0;
            winner_q <= WIN_NONE;
            tick_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            left_q   <= left_d;
            right_q  <= right_d;
            winner_q <= winner_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        left_d   = left_q;
        right_d  = right_q;
        winner_d = winner_q;
        tick_d   = tick_q;
        hold_d   = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                // Start only on a human press; the rope stays centred.
                if (human_press) begin
                    state_d = ST_PLAY;
                    tick_d  = '0;
                end
            end

            ST_PLAY: begin
                tick_d = tick ? '0 : tick_q + TW'(1);
                // Simultaneous presses cancel, so only the exclusive cases act.
                if (human_press && !cyber_press) begin
                    if (pos_q == POS_MIN) begin
                        right_d  = (right_q == 3'(WIN_SCORE)) ? right_q : right_inc[2:0];
                        winner_d = WIN_RIGHT;
                        hold_d   = '0;
                        state_d  = (right_inc == 4'(WIN_SCORE)) ? ST_MATCH_OVER : ST_WON;
                    end else begin
                        pos_d = pos_q - 4'd1;
                    end
                end else if (cyber_press && !human_press) begin
                    if (pos_q == POS_MAX) begin
                        left_d   = (left_q == 3'(WIN_SCORE)) ? left_q : left_inc[2:0];
                        winner_d = WIN_LEFT;
                        hold_d   = '0;
                        state_d  = (left_inc == 4'(WIN_SCORE)) ? ST_MATCH_OVER : ST_WON;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end

            ST_WON: begin
                // Rope stays at the winning edge for the whole hold period.
                if (hold_q == HW'(HOLD_TICKS - 1)) begin
                    hold_d   = '0;
                    tick_d   = '0;
                    pos_d    = POS_CENTRE;
                    winner_d = WIN_NONE;
                    state_d  = ST_PLAY;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end

            ST_MATCH_OVER: begin
                // Terminal until reset.
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign leds        = (state_q == ST_MATCH_OVER) ? 9'h1FF : pos_onehot(pos_q);
    assign pos         = pos_q;
    assign left_score  = left_q;
    assign right_score = right_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule
